irq_scheduler: RTL and testbench
================================

Name: irq_scheduler

Overview:
- Video-timing-driven interrupt scheduler for the i8080 core in the invaders top level.
- Runs the raster counters and raises RST 1 (mid-screen, opcode 0xCF) and RST 2 (vblank, opcode 0xD7) toward the CPU.
- Gates requests on the CPU's INTE, and holds the vector stable for the CPU's interrupt-acknowledge fetch.
- Sits between the video timing and the CPU interrupt inputs; the CPU reads int_vec as the M1 opcode during acknowledge.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (>=1)
- H_TOTAL, 320, pixel ticks per line
- V_TOTAL, 262, lines per frame
- MID_LINE, 96, line whose start raises RST 1
- END_LINE, 224, line whose start raises RST 2; also vblank start

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- inte  in  1  CPU interrupt-enable flip-flop
- inta  in  1  one-cycle pulse: CPU is fetching the interrupt opcode
- int_req  out  1  interrupt request to CPU
- int_vec  out  8  RST opcode to place on the data bus
- hcount  out  9  current pixel column
- vcount  out  9  current line
- vblank  out  1  high while vcount >= END_LINE

Behaviour:
- Reset and decided interface:
  - One clock; reset is synchronous and active-high.
  - Ports are clk and rst.
  - On rst: divider, hcount and vcount = 0; pend_mid and pend_end = 0; state = IDLE; int_req = 0; int_vec = 0x00; vblank = 0.
- Tick and raster counters:
  - tick is high one cycle every CLK_DIV cycles; the first tick is CLK_DIV cycles after reset release.
  - On tick, hcount increments and wraps H_TOTAL-1 -> 0. When hcount wraps, vcount increments and wraps V_TOTAL-1 -> 0.
  - Counters are registered outputs.
- Events:
  - Event fires on the tick that moves hcount to 0 with vcount becoming MID_LINE (sets pend_mid) or END_LINE (sets pend_end).
  - vblank registers high in that same cycle for END_LINE and clears when vcount wraps to 0.
- State machine (IDLE, ASSERT, HOLD):
  - IDLE:
    - If inte and (pend_end or pend_mid), go to ASSERT next cycle with int_req = 1.
    - int_vec latches 0xD7 if pend_end, else 0xCF. Fixed priority: RST 2 over RST 1.
  - ASSERT:
    - int_req = 1; int_vec is held stable and is not re-evaluated, even if a higher-priority event arrives.
    - On inta: clear the pending bit matching the latched vector, drop int_req next cycle, go to HOLD.
    - If inte falls without inta (CPU executed DI): drop int_req, return to IDLE, leave the pending bit set.
    - If inta and the fall of inte coincide, inta wins.
  - HOLD:
    - One cycle, int_req = 0, int_vec unchanged. Gives the CPU time to clear INTE on acknowledge.
    - Then go to IDLE.
- Boundary conditions:
  - inta in IDLE or HOLD: ignored.
  - Event arriving while its own pending bit is already set: absorbed, no second interrupt.
  - Event arriving in the same cycle its bit is cleared by inta: the set wins, and the bit stays pending.
  - rst mid-ASSERT: int_req falls in the reset cycle; all pending bits are lost.
  - MID_LINE == END_LINE is illegal; behaviour with it is not defined.
- int_req is a registered output with no combinational path from any input.

Optional Feature:
- Macro: IRQ_OVERRUN_COUNT_EN.
- With the macro defined:
  - Adds output overrun_cnt [7:0], reset 0.
  - Increments, saturating at 0xFF, on every event absorbed because its pending bit was already set and not being cleared in that cycle.
  - Two events absorbed in the same cycle count +2.
  - Exists so software can detect missed frames.
- Without it: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Bench parameters: CLK_DIV=1, H_TOTAL=4, V_TOTAL=8, MID_LINE=2, END_LINE=6, inte=1; auto-ack with inta one cycle after int_req.
- Free run:
  - hcount sequence 0,1,2,3,0; vcount reaches 7 then wraps to 0 after 32 ticks.
  - vblank high exactly for vcount 6..7.
- Basic interrupts:
  - int_req rises 1 cycle after the line-2 event with int_vec = 0xCF.
  - A second request follows at line 6 with int_vec = 0xD7.
  - int_req is low during HOLD after each inta.
- inte=0 across a frame:
  - int_req stays 0 while both pend bits set.
  - Raising inte gives int_req with int_vec = 0xD7; after its inta, 2 cycles later (via HOLD, IDLE), 0xCF.
- DI while asserted:
  - Drop inte during ASSERT -> int_req = 0 next cycle.
  - Re-raise inte -> same vector re-requested; pending bit was not lost.
- Reset mid-ASSERT: assert rst while int_req = 1 -> next cycle int_req = 0, hcount = 0, vcount = 0, no request until the next line-2 event.
- With IRQ_OVERRUN_COUNT_EN and inte=0 for 3 frames: overrun_cnt = 4 (2 per frame after the first).

Source files
------------

// File: rtl/irq_scheduler.sv
// irq_scheduler: raster counters plus RST 1 / RST 2 interrupt sequencing for the i8080.
// Optional IRQ_OVERRUN_COUNT_EN adds a saturating count of events absorbed by an already pending request.
module irq_scheduler #(
    parameter int CLK_DIV  = 2,
    parameter int H_TOTAL  = 320,
    parameter int V_TOTAL  = 262,
    parameter int MID_LINE = 96,
    parameter int END_LINE = 224
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inte,
    input  logic       inta,
    output logic       int_req,
    output logic [7:0] int_vec,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
`ifdef IRQ_OVERRUN_COUNT_EN
    output logic [7:0] overrun_cnt,
`endif
    output logic       vblank
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] RST1 = 8'hCF;
    localparam logic [7:0] RST2 = 8'hD7;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    state_t state, state_n;
    logic [DW-1:0] div;
    logic [7:0] vec_n;
    logic [8:0] v_next;
    logic tick, h_wrap, ev_mid, ev_end, clr_mid, clr_end, pend_mid, pend_end;

    assign tick   = div == DW'(CLK_DIV - 1);
    assign h_wrap = tick && hcount == 9'(H_TOTAL - 1);
    assign v_next = vcount == 9'(V_TOTAL - 1) ? 9'd0 : vcount + 9'd1;
    assign ev_mid = h_wrap && v_next == 9'(MID_LINE);
    assign ev_end = h_wrap && v_next == 9'(END_LINE);

    always_comb begin
        state_n = state;
        vec_n   = int_vec;
        clr_mid = 1'b0;
        clr_end = 1'b0;
        case (state)
            IDLE: if (inte && (pend_end || pend_mid)) begin
                state_n = ASSERT;
                vec_n   = pend_end ? RST2 : RST1;
            end
            ASSERT: if (inta) begin
                state_n = HOLD;
                clr_mid = int_vec == RST1;
                clr_end = int_vec == RST2;
            end else if (!inte) begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            hcount   <= '0;
            vcount   <= '0;
            vblank   <= 1'b0;
            pend_mid <= 1'b0;
            pend_end <= 1'b0;
            state    <= IDLE;
            int_req  <= 1'b0;
            int_vec  <= 8'h00;
        end else begin
            div      <= tick ? '0 : div + DW'(1);
            hcount   <= tick ? (h_wrap ? 9'd0 : hcount + 9'd1) : hcount;
            vcount   <= h_wrap ? v_next : vcount;
            vblank   <= ev_end ? 1'b1 : (h_wrap && v_next == 9'd0) ? 1'b0 : vblank;
            // a new event beats a same-cycle acknowledge clear
            pend_mid <= ev_mid | (pend_mid & ~clr_mid);
            pend_end <= ev_end | (pend_end & ~clr_end);
            state    <= state_n;
            int_req  <= state_n == ASSERT;
            int_vec  <= vec_n;
        end
    end

`ifdef IRQ_OVERRUN_COUNT_EN
    logic [8:0] ovr_sum;

    assign ovr_sum = {1'b0, overrun_cnt} + 9'(ev_mid & pend_mid & ~clr_mid)
                                         + 9'(ev_end & pend_end & ~clr_end);

    always_ff @(posedge clk) begin
        if (rst) overrun_cnt <= 8'd0;
        else     overrun_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end
`endif
endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler: randomized and directed checks of irq_scheduler against an arithmetic raster / request model.
module tb_irq_scheduler;
    localparam int CD = 1, H = 4, V = 8, MID = 2, ENDL = 6;

    logic clk = 0, rst = 1, inte = 1, inta = 0;
    logic int_req, vblank;
    logic [7:0] int_vec;
    logic [8:0] hcount, vcount;
`ifdef IRQ_OVERRUN_COUNT_EN
    logic [7:0] overrun_cnt;
`endif

    int compared = 0, mismatched = 0;
    int amode = 0;
    bit chk_en = 0;

    irq_scheduler #(.CLK_DIV(CD), .H_TOTAL(H), .V_TOTAL(V), .MID_LINE(MID), .END_LINE(ENDL)) dut (
        .clk(clk), .rst(rst), .inte(inte), .inta(inta),
        .int_req(int_req), .int_vec(int_vec), .hcount(hcount), .vcount(vcount),
`ifdef IRQ_OVERRUN_COUNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .vblank(vblank)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raster position is pure arithmetic on the number of clocks since reset release.
    int e = 0, m_ovr = 0;
    bit m_pm = 0, m_pe = 0, m_req = 0, m_hold = 0;
    logic [7:0] m_vec = 8'h00;

    always @(posedge clk) begin
        bit ev_m, ev_e, cm, ce;
        int p;
        if (rst) begin
            e = 0; m_pm = 0; m_pe = 0; m_req = 0; m_hold = 0; m_vec = 8'h00; m_ovr = 0;
        end else begin
            e++;
            p = e / CD;
            ev_m = (e % CD == 0) && (p % H == 0) && ((p / H) % V == MID);
            ev_e = (e % CD == 0) && (p % H == 0) && ((p / H) % V == ENDL);
            cm = 0; ce = 0;
            if (m_req) begin
                if (inta) begin
                    cm = m_vec == 8'hCF; ce = m_vec == 8'hD7; m_req = 0; m_hold = 1;
                end else if (!inte) m_req = 0;
            end else if (m_hold) m_hold = 0;
            else if (inte && (m_pe || m_pm)) begin
                m_req = 1; m_vec = m_pe ? 8'hD7 : 8'hCF;
            end
            m_ovr += int'(ev_m && m_pm && !cm) + int'(ev_e && m_pe && !ce);
            if (m_ovr > 255) m_ovr = 255;
            m_pm = ev_m || (m_pm && !cm);
            m_pe = ev_e || (m_pe && !ce);
        end
    end

    always @(negedge clk) if (chk_en) begin
        int ev;
        ev = ((e / CD) / H) % V;
        check("hcount", hcount, (e / CD) % H);
        check("vcount", vcount, ev);
        check("vblank", vblank, int'(ev >= ENDL));
        check("int_req", int_req, int'(m_req));
        check("int_vec", int_vec, m_vec);
`ifdef IRQ_OVERRUN_COUNT_EN
        check("overrun_cnt", overrun_cnt, m_ovr);
`endif
    end

    // amode: 0 no acknowledge, 1 acknowledge one cycle after int_req, 2 random inta
    always @(negedge clk)
        inta = amode == 2 ? ($urandom_range(0, 3) == 0) : (amode == 1 && int_req);

    task automatic wait_hv(input int v, input int h);
        int n = 0;
        while (!(vcount == 9'(v) && hcount == 9'(h)) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            compared++; mismatched++;
            $display("FAIL wait_hv: position %0d/%0d not reached", v, h);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!int_req && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            compared++; mismatched++;
            $display("FAIL wait_req: int_req never rose");
        end
    endtask

    initial begin
        logic [7:0] vsave;
        int i;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_hcount", hcount, 0);
        check("rst_req", int_req, 0);
        check("rst_vec", int_vec, 0);
        check("rst_vblank", vblank, 0);
        rst = 0; amode = 1;
        repeat (31) @(negedge clk);
        check("free_h31", hcount, 3);
        check("free_v31", vcount, 7);
        check("free_vb31", vblank, 1);
        @(negedge clk);
        check("wrap_h", hcount, 0);
        check("wrap_v", vcount, 0);
        check("wrap_vb", vblank, 0);
        wait_hv(MID, 0);
        @(negedge clk);
        check("mid_req", int_req, 1);
        check("mid_vec", int_vec, 8'hCF);
        @(negedge clk);
        check("mid_hold", int_req, 0);
        wait_hv(ENDL, 0);
        @(negedge clk);
        check("end_req", int_req, 1);
        check("end_vec", int_vec, 8'hD7);
        @(negedge clk);
        check("end_hold", int_req, 0);
        inte = 0;
        repeat (40) @(negedge clk);
        check("masked_req", int_req, 0);
        wait_hv(0, 1);
        inte = 1;
        @(negedge clk);
        check("both_first_req", int_req, 1);
        check("both_first_vec", int_vec, 8'hD7);
        @(negedge clk);
        check("both_hold", int_req, 0);
        @(negedge clk);
        check("both_idle", int_req, 0);
        @(negedge clk);
        check("both_second_req", int_req, 1);
        check("both_second_vec", int_vec, 8'hCF);
        amode = 0;
        @(negedge clk);
        wait_req();
        vsave = int_vec;
        inte = 0;
        @(negedge clk);
        check("di_drop", int_req, 0);
        inte = 1;
        @(negedge clk);
        check("di_rereq", int_req, 1);
        check("di_vec", int_vec, vsave);
        @(negedge clk);
        wait_req();
        rst = 1;
        @(negedge clk);
        check("rst_assert_req", int_req, 0);
        check("rst_assert_h", hcount, 0);
        check("rst_assert_v", vcount, 0);
        rst = 0; amode = 1;
        for (i = 1; i < 40 && !int_req; i++) @(negedge clk);
        check("rst_next_req_delay", i - 1, 9);
        check("rst_next_vec", int_vec, 8'hCF);
        rst = 1;
        @(negedge clk);
        rst = 0; inte = 0; amode = 0;
        repeat (96) @(negedge clk);
        check("ovr_no_req", int_req, 0);
`ifdef IRQ_OVERRUN_COUNT_EN
        check("ovr_three_frames", overrun_cnt, 4);
`endif
        inte = 1; amode = 1;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            rst = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 24) == 0) inte = ~inte;
            if ($urandom_range(0, 49) == 0) amode = $urandom_range(0, 2);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
